// File: rtl/sipo_receiver.sv
// Framed serial-to-parallel receiver: WIDTH bits MSB-first on Sclk, one DataReady pulse per word.
// Define SIPO_PARITY_CHECK_EN to expect and check one trailing even-parity bit per frame.
module sipo_receiver #(
   parameter int WIDTH = 40
) (
   input  logic             Sclk,
   input  logic             Clear_n,
   input  logic             Frame,
   input  logic             InReady,
   input  logic             InputSerial,
   output logic [WIDTH-1:0] OutputParallel,
   output logic             DataReady,
   output logic             FrameErr,
   output logic             ParityErr,
   output logic             Busy
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

`ifdef SIPO_PARITY_CHECK_EN
   typedef enum logic [1:0] {IDLE, RECV, PARITY} state_t;
`else
   typedef enum logic [1:0] {IDLE, RECV} state_t;
`endif

   state_t           state_reg, state_next;
   logic [CW-1:0]    count_reg, count_next;
   logic [WIDTH-1:0] shift_reg, shift_next;
   logic [WIDTH-1:0] out_reg, out_next;
   logic             ready_reg, ready_next;
   logic             ferr_reg, ferr_next;
`ifdef SIPO_PARITY_CHECK_EN
   logic             perr_reg, perr_next;
`endif

   always_ff @(posedge Sclk) begin
      if (!Clear_n) begin
         state_reg <= IDLE;
         count_reg <= '0;
         shift_reg <= '0;
         out_reg   <= '0;
         ready_reg <= 1'b0;
         ferr_reg  <= 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
         perr_reg  <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         shift_reg <= shift_next;
         out_reg   <= out_next;
         ready_reg <= ready_next;
         ferr_reg  <= ferr_next;
`ifdef SIPO_PARITY_CHECK_EN
         perr_reg  <= perr_next;
`endif
      end
   end

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      shift_next = shift_reg;
      out_next   = out_reg;
      ready_next = 1'b0;
      ferr_next  = ferr_reg;
`ifdef SIPO_PARITY_CHECK_EN
      perr_next  = perr_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (Frame && InReady) begin
               shift_next = {{(WIDTH-1){1'b0}}, InputSerial};
               count_next = CW'(WIDTH - 1);
               state_next = RECV;
            end
         end
         RECV: begin
            if (!InReady) begin
               ferr_next  = 1'b1;
               state_next = IDLE;
            end else begin
               shift_next = {shift_reg[WIDTH-2:0], InputSerial};
               count_next = count_reg - CW'(1);
               // counter hits zero on this edge: this is the last data bit
               if (count_reg == CW'(1)) begin
                  out_next = {shift_reg[WIDTH-2:0], InputSerial};
`ifdef SIPO_PARITY_CHECK_EN
                  state_next = PARITY;
`else
                  ready_next = 1'b1;
                  state_next = IDLE;
`endif
               end
            end
         end
`ifdef SIPO_PARITY_CHECK_EN
         PARITY: begin
            state_next = IDLE;
            if (!InReady) begin
               ferr_next = 1'b1;
            end else if (InputSerial == (^out_reg)) begin
               ready_next = 1'b1;
            end else begin
               perr_next = 1'b1;
            end
         end
`endif
         default: state_next = IDLE;
      endcase
   end

   assign OutputParallel = out_reg;
   assign DataReady      = ready_reg;
   assign FrameErr       = ferr_reg;
   assign Busy           = (state_reg != IDLE);
`ifdef SIPO_PARITY_CHECK_EN
   assign ParityErr      = perr_reg;
`else
   assign ParityErr      = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_receiver.sv
// Directed bench for sipo_receiver; expected words queued at send time and popped on DataReady.
module tb_sipo_receiver;

   localparam int W = 40;
`ifdef SIPO_PARITY_CHECK_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif

   logic         Sclk = 1'b0;
   logic         Clear_n = 1'b0;
   logic         Frame = 1'b0;
   logic         InReady = 1'b0;
   logic         InputSerial = 1'b0;
   logic [W-1:0] OutputParallel;
   logic         DataReady;
   logic         FrameErr;
   logic         ParityErr;
   logic         Busy;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int pulses = 0;
   int last_pulse = 0;
   int last_gap = 0;
   logic [W-1:0] exp_q[$];

   sipo_receiver #(.WIDTH(W)) dut (
      .Sclk(Sclk), .Clear_n(Clear_n), .Frame(Frame), .InReady(InReady),
      .InputSerial(InputSerial), .OutputParallel(OutputParallel),
      .DataReady(DataReady), .FrameErr(FrameErr), .ParityErr(ParityErr), .Busy(Busy)
   );

   always #5 Sclk = ~Sclk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // one clock edge; outputs sampled 1 time unit later and DataReady drained into the scoreboard
   task automatic tick();
      @(posedge Sclk);
      #1;
      cyc++;
      if (DataReady === 1'b1) begin
         pulses++;
         last_gap = cyc - last_pulse;
         last_pulse = cyc;
         compared++;
         assert (exp_q.size() != 0) else begin
            mismatched++;
            $error("FAIL spurious_ready: observed DataReady=1 word %h expected no pulse", OutputParallel);
         end
         if (exp_q.size() != 0) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            check("word", 64'(OutputParallel), 64'(e));
         end
      end
   endtask

   task automatic idle(input int n);
      Frame = 1'b0;
      InReady = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send(input logic [W-1:0] w, input int nbits, input logic bad_par, input bit stray);
      if (nbits == W && !(PB == 1 && bad_par)) exp_q.push_back(w);
      for (int i = 0; i < nbits; i++) begin
         Frame = (i == 0) || (stray && (i % 7 == 3));
         InReady = 1'b1;
         InputSerial = w[W-1-i];
         tick();
      end
      if (PB == 1 && nbits == W) begin
         Frame = 1'b0;
         InputSerial = (^w) ^ bad_par;
         tick();
      end
      Frame = 1'b0;
   endtask

   initial begin
      int p0;
      // reset
      Clear_n = 1'b0;
      tick();
      tick();
      Clear_n = 1'b1;
      idle(1);
      check("rst_out", 64'(OutputParallel), 64'h0);
      check("rst_ready", 64'(DataReady), 64'h0);
      check("rst_ferr", 64'(FrameErr), 64'h0);
      check("rst_busy", 64'(Busy), 64'h0);
      check("rst_perr", 64'(ParityErr), 64'h0);

      // Frame without InReady is ignored
      Frame = 1'b1;
      InReady = 1'b0;
      tick();
      check("frame_no_ready_busy", 64'(Busy), 64'h0);

      // single frame
      send(40'hA5_1234_5678, W, 1'b0, 1'b0);
      check("single_pulse", 64'(pulses), 64'd1);
      check("single_busy", 64'(Busy), 64'h0);
      idle(1);
      check("single_ready_1cyc", 64'(DataReady), 64'h0);
      check("single_hold", 64'(OutputParallel), 64'hA5_1234_5678);
      $display("txn single: out=%h pulses=%0d", OutputParallel, pulses);

      // back-to-back
      send(40'hFF_FFFF_FFFF, W, 1'b0, 1'b0);
      send(40'h00_0000_0001, W, 1'b0, 1'b0);
      idle(2);
      check("b2b_pulses", 64'(pulses), 64'd3);
      check("b2b_gap", 64'(last_gap), 64'(W + PB));
      check("b2b_out", 64'(OutputParallel), 64'h1);
      $display("txn b2b: out=%h gap=%0d", OutputParallel, last_gap);

      // abort after 20 bits
      p0 = pulses;
      send(40'hA5_1234_5678, 20, 1'b0, 1'b0);
      check("abort_busy_mid", 64'(Busy), 64'h1);
      idle(3);
      check("abort_ferr", 64'(FrameErr), 64'h1);
      check("abort_no_ready", 64'(pulses), 64'(p0));
      check("abort_out_kept", 64'(OutputParallel), 64'h1);
      check("abort_idle", 64'(Busy), 64'h0);
      send(40'h0F_0F0F_0F0F, W, 1'b0, 1'b0);
      idle(1);
      check("after_abort_out", 64'(OutputParallel), 64'h0F_0F0F_0F0F);
      check("ferr_sticky", 64'(FrameErr), 64'h1);
      $display("txn abort: ferr=%b out=%h", FrameErr, OutputParallel);

      // reset mid-frame
      send(40'h12_3456_789A, 10, 1'b0, 1'b0);
      Clear_n = 1'b0;
      tick();
      Clear_n = 1'b1;
      InReady = 1'b0;
      idle(1);
      check("midrst_busy", 64'(Busy), 64'h0);
      check("midrst_out", 64'(OutputParallel), 64'h0);
      check("midrst_ferr", 64'(FrameErr), 64'h0);
      $display("txn midreset: busy=%b out=%h", Busy, OutputParallel);

      // stray Frame pulses inside RECV
      send(40'hC3_5A69_96E1, W, 1'b0, 1'b1);
      idle(2);
      check("stray_out", 64'(OutputParallel), 64'hC3_5A69_96E1);
      check("stray_ferr", 64'(FrameErr), 64'h0);
      $display("txn stray: out=%h", OutputParallel);

`ifdef SIPO_PARITY_CHECK_EN
      p0 = pulses;
      send(40'h00_0000_0003, W, 1'b0, 1'b0);
      idle(1);
      check("par_ok_pulse", 64'(pulses), 64'(p0 + 1));
      check("par_ok_perr", 64'(ParityErr), 64'h0);
      send(40'h00_0000_0003, W, 1'b1, 1'b0);
      idle(2);
      check("par_bad_perr", 64'(ParityErr), 64'h1);
      check("par_bad_no_pulse", 64'(pulses), 64'(p0 + 1));
      check("par_bad_out", 64'(OutputParallel), 64'h3);
      $display("txn parity: perr=%b out=%h", ParityErr, OutputParallel);
`else
      check("perr_tied", 64'(ParityErr), 64'h0);
`endif

      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/sipo_receiver.md
Name: sipo_receiver

Overview:
- Serial-to-parallel receiver; the far end of the framed serial link driven by our parallel-in/serial-out transmitter.
- Detects the start of a frame, shifts in WIDTH bits MSB-first on Sclk, and presents the assembled word on OutputParallel.
- DataReady pulses once per completed word.
- Sits in the receive datapath, ahead of the parallel word consumers.

Parameters:
WIDTH, 40, bits per frame (data word width, MSB sent first)

Ports:
Sclk  input  1  serial bit clock; all logic on posedge
Clear_n  input  1  synchronous active-low reset, sampled on posedge Sclk
Frame  input  1  frame-start strobe; high in the cycle the MSB is on InputSerial
InReady  input  1  link valid; high in every cycle that InputSerial carries a frame bit
InputSerial  input  1  serial data, MSB first
OutputParallel  output  WIDTH  last completed word; held until the next completion
DataReady  output  1  one-cycle pulse; OutputParallel has just been updated
FrameErr  output  1  sticky; a frame was aborted because InReady dropped mid-frame
ParityErr  output  1  sticky parity mismatch (see Optional Feature); constant 0 when the feature is compiled out
Busy  output  1  high while in RECV or PARITY state

Behaviour:
- Clock and reset: one clock, Sclk. Reset is synchronous, active-low (Clear_n) and has priority over all other logic.
- Reset values:
  - State = IDLE.
  - Bit counter = 0; shift register = 0.
  - OutputParallel = 0.
  - DataReady, FrameErr, ParityErr, Busy = 0.
- States: IDLE, RECV, PARITY (PARITY exists only with the feature enabled).
- IDLE:
  - On an edge with Frame=1 and InReady=1: sample InputSerial as bit WIDTH-1, set counter = WIDTH-1, go to RECV.
  - Frame=1 with InReady=0 is ignored.
- RECV:
  - Each edge with InReady=1: shift InputSerial into the LSB side and decrement the counter.
  - Frame is ignored in RECV; a Frame pulse in RECV does not restart the frame.
  - Last data bit (counter reaches 0 on this edge):
    - Load OutputParallel = {shift[WIDTH-2:0], InputSerial} on that same edge.
    - Go to IDLE, or to PARITY if the feature is enabled.
  - Any edge with InReady=0: abort the frame.
    - Discard the partial word; OutputParallel is unchanged.
    - Set FrameErr=1 and go to IDLE; no DataReady.
- Latency and DataReady:
  - The first bit is sampled on the Frame edge, so WIDTH sampling edges in total.
  - DataReady is high for exactly the one cycle following the edge that loads OutputParallel.
- Back-to-back frames:
  - A Frame+InReady on the edge immediately after the last bit (or after the parity bit) is accepted.
  - No idle gap is required.
- Sticky errors: FrameErr and ParityErr clear only on reset.
- Reset mid-frame: returns to IDLE on that edge. The partial word is lost and OutputParallel reads 0 afterwards.
- Busy = 1 exactly while state is RECV or PARITY.

Optional Feature:
- Macro: SIPO_PARITY_CHECK_EN.
- Enabled:
  - One extra bit follows the last data bit, with InReady=1; the state machine samples it in PARITY.
  - Expected value is even parity, i.e. XOR of all WIDTH data bits.
  - Match: DataReady pulses in the cycle after the parity edge.
  - Mismatch: set ParityErr, suppress DataReady; OutputParallel still holds the new word.
  - InReady=0 in PARITY: treat as abort (FrameErr=1, no DataReady).
- Disabled: no PARITY state; ParityErr is tied 0; DataReady follows the last data bit as described in Behaviour.

Test Plan:
- Reset: Clear_n=0 for 2 edges, then release -> OutputParallel=0, DataReady=0, FrameErr=0, Busy=0.
- Single frame, 40'hA5_1234_5678 MSB-first, Frame on the first bit, InReady held for 40 edges -> OutputParallel=40'hA512345678, DataReady high for exactly 1 cycle, Busy low after the last bit.
- Back-to-back frames 40'hFF_FFFF_FFFF then 40'h00_0000_0001, with the second Frame on the edge right after the last bit -> two DataReady pulses 40 cycles apart, OutputParallel ends at 40'h0000000001.
- Abort: send 20 bits of 40'hA5_1234_5678, then InReady=0 for one edge -> FrameErr=1 (sticky), no DataReady, OutputParallel keeps its prior value; the next full frame 40'h0F_0F0F_0F0F completes normally.
- Reset mid-frame: Clear_n=0 after 10 bits -> IDLE, Busy=0, OutputParallel=0; stray Frame pulses during RECV of a later frame do not restart it.
- SIPO_PARITY_CHECK_EN:
  - 40'h00_0000_0003 with parity bit 0 -> DataReady pulses, ParityErr=0.
  - Same word with parity bit 1 -> ParityErr=1, no DataReady, OutputParallel=40'h0000000003.
